// File: rtl/pmem_line_responder.sv
// ---------------------------------------------------------------------------
// pmem_line_responder
//
// Responder end of the cache-line physical-memory handshake that sits between
// the L2 / eviction write buffer and memory. It accepts one line read or line
// write at a time and completes it after a fixed latency with a single-cycle
// pmem_resp pulse. A small on-chip line store with per-line valid bits backs
// the requests, so the block can act as a synthesizable memory endpoint during
// L2/EWB bring-up.
//
// Parameters
//   LINE_WIDTH   bits per cache line
//   ADDR_WIDTH   request address width
//   OFFSET_BITS  byte-offset bits skipped when forming the line index
//   INDEX_BITS   line-store index bits (depth = 2**INDEX_BITS)
//   LATENCY      cycles from acceptance to pmem_resp (1..255)
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-high reset
//   pmem_read       in   line read request, held until pmem_resp
//   pmem_write      in   line write request, held until pmem_resp
//   pmem_address    in   request address
//   pmem_wdata      in   write line data
//   pmem_resp       out  one-cycle completion pulse (registered)
//   pmem_rdata      out  read line data, valid while pmem_resp is high
//   protocol_error  out  sticky flag: read and write requested together
//   read_count      out  completed reads, wraps at 2**16
//   write_count     out  completed writes, wraps at 2**16
// ---------------------------------------------------------------------------
module pmem_line_responder #(
    parameter int LINE_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 16,
    parameter int OFFSET_BITS = 4,
    parameter int INDEX_BITS  = 6,
    parameter int LATENCY     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [ADDR_WIDTH-1:0] pmem_address,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic                  pmem_resp,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  protocol_error,
    output logic [15:0]           read_count,
    output logic [15:0]           write_count
);

    localparam int DEPTH = 2 ** INDEX_BITS;

    // Reload value for the BUSY countdown; BUSY lasts exactly LATENCY cycles.
    localparam logic [7:0] LAT_RELOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        DONE
    } state_t;

    state_t                  state;
    logic                    op_write;
    logic [INDEX_BITS-1:0]   op_idx;
    logic [LINE_WIDTH-1:0]   op_wdata;
    logic [7:0]              cnt;

    logic [LINE_WIDTH-1:0]   line_store [DEPTH];
    logic [DEPTH-1:0]        line_valid;

    logic [INDEX_BITS-1:0]   req_idx;
    logic                    finishing;
    logic                    unused_addr_bits;

    // Address bits above the index alias onto the same line; the offset bits
    // select bytes inside a line and play no part in indexing.
    assign req_idx = pmem_address[OFFSET_BITS +: INDEX_BITS];

    assign unused_addr_bits = ^{pmem_address[OFFSET_BITS-1:0],
                                pmem_address[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS]};

    // High on the last BUSY cycle: the edge that ends it moves the FSM into
    // RESP, and every visible effect of the transaction lands on that edge.
    assign finishing = (state == BUSY) && (cnt == 8'd0);

    // Main control FSM. All outputs are registered here, so pmem_resp never
    // depends combinationally on the request inputs and the initiator may drop
    // its request as soon as it sees pmem_resp. The store commit, valid bit,
    // read data and counters are all updated on the edge into RESP so that
    // they are coherent with the pmem_resp pulse. A reset arriving before that
    // edge simply discards the latched request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            op_write       <= 1'b0;
            op_idx         <= '0;
            op_wdata       <= '0;
            cnt            <= 8'd0;
            pmem_resp      <= 1'b0;
            pmem_rdata     <= '0;
            protocol_error <= 1'b0;
            read_count     <= 16'd0;
            write_count    <= 16'd0;
            line_valid     <= '0;
        end else begin
            pmem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (pmem_read || pmem_write) begin
                        // A simultaneous read and write is resolved as a write
                        // and flagged; the flag stays until reset.
                        op_write <= pmem_write;
                        op_idx   <= req_idx;
                        op_wdata <= pmem_wdata;
                        cnt      <= LAT_RELOAD;
                        state    <= BUSY;
                        if (pmem_read && pmem_write) begin
                            protocol_error <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 8'd0) begin
                        state     <= RESP;
                        pmem_resp <= 1'b1;
                        if (op_write) begin
                            line_valid[op_idx] <= 1'b1;
                            write_count        <= write_count + 16'd1;
                        end else begin
                            pmem_rdata <= line_valid[op_idx] ? line_store[op_idx]
                                                             : '0;
                            read_count <= read_count + 16'd1;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    state <= DONE;
                end
                DONE: begin
                    // Recovery cycle: a held request is picked up in IDLE next.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line store data array. It has no reset so it maps onto RAM; stale
    // contents are hidden by the cleared valid bits. The reset term stops a
    // write from committing on the same edge that aborts it.
    always_ff @(posedge clk) begin
        if (!reset && finishing && op_write) begin
            line_store[op_idx] <= op_wdata;
        end
    end

endmodule

// File: tb/tb_pmem_line_responder.sv
// ---------------------------------------------------------------------------
// tb_pmem_line_responder
//
// Self-checking bench for pmem_line_responder at its default parameters.
// A table of transactions (inputs plus expected read data, counters and error
// flag) is applied in order; hand-written sequences cover reset during BUSY,
// back-to-back held reads and the read counter wrap. Expected responses are
// queued when a request is driven and popped by a monitor when pmem_resp
// fires, which checks both arrival cycle and line data.
// ---------------------------------------------------------------------------
module tb_pmem_line_responder;

    localparam int LAT = 4;

    logic         clk;
    logic         reset;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic         protocol_error;
    logic [15:0]  read_count;
    logic [15:0]  write_count;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_rdata;
        logic [15:0]  exp_rc;
        logic [15:0]  exp_wc;
        logic         exp_perr;
    } vec_t;

    typedef struct {
        logic [127:0] rdata;
        int           cyc;
    } sb_t;

    localparam logic [127:0] D1 = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    localparam logic [127:0] D2 = 128'hA5A5_5A5A_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] D3 = 128'h0F0F_F0F0_7777_8888_9999_AAAA_BBBB_CCCC;
    localparam logic [127:0] D4 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [127:0] D5 = 128'h5555_0000_5555_0000_5555_0000_5555_0005;
    localparam logic [127:0] D6 = 128'h6666_0000_6666_0000_6666_0000_6666_0006;
    localparam logic [127:0] D7 = 128'h7777_0000_7777_0000_7777_0000_7777_0007;
    localparam logic [127:0] D9 = 128'h9999_9999_9999_9999_9999_9999_9999_9999;

    vec_t vecs [18];
    sb_t  sb [$];
    sb_t  mon_e;
    int   cyc;
    int   checks;
    int   errors;

    pmem_line_responder #(
        .LINE_WIDTH (128),
        .ADDR_WIDTH (16),
        .OFFSET_BITS(4),
        .INDEX_BITS (6),
        .LATENCY    (LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_resp     (pmem_resp),
        .pmem_rdata    (pmem_rdata),
        .protocol_error(protocol_error),
        .read_count    (read_count),
        .write_count   (write_count)
    );

    // Free-running clock and a cycle counter used to time responses.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every pmem_resp must match the oldest queued entry
    // in both its arrival cycle and its line data.
    always @(negedge clk) begin
        if (!reset && pmem_resp) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_resp", 128'd1, 128'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("resp_cycle", 128'(mon_e.cyc), 128'(cyc));
                checkOutput("resp_rdata", pmem_rdata, mon_e.rdata);
            end
        end
    end

    // Waits for pmem_resp with a bounded budget; a timeout counts as a failure.
    task automatic waitResp();
        int n;
        n = 0;
        @(negedge clk);
        while (!pmem_resp && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!pmem_resp) begin
            checkOutput("resp_timeout", 128'd0, 128'd1);
            sb.delete();
        end
    endtask

    // Drives one table transaction in an IDLE cycle, queues its expected
    // response, holds the request until pmem_resp, then checks the pulse is
    // one cycle wide and the counters / error flag afterwards.
    task automatic applyStimulus(input vec_t v, input int idx);
        sb_t e;
        @(posedge clk);
        #1;
        pmem_read    = v.rd;
        pmem_write   = v.wr;
        pmem_address = v.addr;
        pmem_wdata   = v.wdata;
        e.rdata      = v.exp_rdata;
        e.cyc        = cyc + LAT + 1;
        sb.push_back(e);
        waitResp();
        @(posedge clk);
        #1;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("resp_pulse[%0d]", idx), 128'(pmem_resp), 128'd0);
        checkOutput($sformatf("read_count[%0d]", idx), 128'(read_count), 128'(v.exp_rc));
        checkOutput($sformatf("write_count[%0d]", idx), 128'(write_count), 128'(v.exp_wc));
        checkOutput($sformatf("protocol_error[%0d]", idx), 128'(protocol_error),
                    128'(v.exp_perr));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int n;
        int resp_seen;

        checks = 0;
        errors = 0;

        // rd, wr, addr, wdata, exp_rdata (held value for writes), rc, wc, perr
        vecs[0]  = '{1'b1, 1'b0, 16'h0040, 128'h0, 128'h0, 16'd1, 16'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 16'h0040, D1,     128'h0, 16'd1, 16'd1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0040, 128'h0, D1,     16'd2, 16'd1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 16'h0440, D2,     D1,     16'd2, 16'd2, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0040, 128'h0, D2,     16'd3, 16'd2, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 16'h0440, 128'h0, D2,     16'd4, 16'd2, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 16'h0010, D3,     D2,     16'd4, 16'd3, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 16'h0010, 128'h0, D3,     16'd5, 16'd3, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 16'h0030, 128'h0, 128'h0, 16'd6, 16'd3, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 16'h004F, D4,     128'h0, 16'd6, 16'd4, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 16'h0040, 128'h0, D4,     16'd7, 16'd4, 1'b1};
        // after the mid-BUSY reset
        vecs[11] = '{1'b1, 1'b0, 16'h0020, 128'h0, 128'h0, 16'd1, 16'd0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 16'h0040, 128'h0, 128'h0, 16'd2, 16'd0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 16'h0050, D5,     128'h0, 16'd2, 16'd1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 16'h0060, D6,     128'h0, 16'd2, 16'd2, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 16'h0070, D7,     128'h0, 16'd2, 16'd3, 1'b0};
        // read counter wrap, starting from a preloaded 16'hFFFE
        vecs[16] = '{1'b1, 1'b0, 16'h0050, 128'h0, D5,     16'hFFFF, 16'd3, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 16'h0070, 128'h0, D7,     16'h0000, 16'd3, 1'b0};

        reset        = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0;
        pmem_wdata   = 128'h0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_resp", 128'(pmem_resp), 128'd0);
        checkOutput("reset_rdata", pmem_rdata, 128'd0);
        checkOutput("reset_perr", 128'(protocol_error), 128'd0);
        checkOutput("reset_rc", 128'(read_count), 128'd0);
        checkOutput("reset_wc", 128'(write_count), 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic reads/writes, aliasing, offset bits, read+write collision.
        for (int i = 0; i <= 10; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset during BUSY of a write to 0x0020: no response, nothing commits.
        @(posedge clk);
        #1;
        pmem_write   = 1'b1;
        pmem_address = 16'h0020;
        pmem_wdata   = D9;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_resp", 128'(pmem_resp), 128'd0);
        checkOutput("abort_rc", 128'(read_count), 128'd0);
        checkOutput("abort_wc", 128'(write_count), 128'd0);
        checkOutput("abort_perr", 128'(protocol_error), 128'd0);
        checkOutput("abort_rdata", pmem_rdata, 128'd0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        pmem_write = 1'b0;
        resp_seen  = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (pmem_resp) resp_seen++;
        end
        checkOutput("abort_no_resp", 128'(resp_seen), 128'd0);

        // Read back after reset, then preload lines for the held-read run.
        for (int i = 11; i <= 15; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Three reads with pmem_read held high; the address changes while the
        // previous read is still BUSY, so each response must carry the line
        // latched at its own acceptance. The read drops mid-BUSY of the third.
        @(posedge clk);
        #1;
        t0           = cyc;
        pmem_read    = 1'b1;
        pmem_write   = 1'b0;
        pmem_address = 16'h0050;
        sb.push_back('{D5, t0 + LAT + 1});
        sb.push_back('{D6, t0 + 2 * LAT + 4});
        sb.push_back('{D7, t0 + 3 * LAT + 7});
        @(posedge clk);
        #1;
        pmem_address = 16'h0060;
        repeat (7) @(posedge clk);
        #1;
        pmem_address = 16'h0070;
        repeat (7) @(posedge clk);
        #1;
        pmem_read    = 1'b0;
        pmem_address = 16'h0000;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_drain", 128'(sb.size()), 128'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_rc", 128'(read_count), 128'd5);
        checkOutput("b2b_wc", 128'(write_count), 128'd3);
        checkOutput("b2b_rdata_hold", pmem_rdata, D7);

        // Preload the read counter near its limit instead of running 65536
        // transactions, then complete two reads across the wrap.
        force dut.read_count = 16'hFFFE;
        #2;
        release dut.read_count;
        for (int i = 16; i <= 17; i++) begin
            applyStimulus(vecs[i], i);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
